// File: rtl/rssb_core.sv
// One-instruction RSSB processor: copies the first DEPTH ROM words into a private RAM,
// then executes reverse-subtract-and-skip-if-borrow instructions from it until a halt word.
module rssb_core #(
  parameter int unsigned        WIDTH    = 8,
  parameter int unsigned        DEPTH    = 16,
  localparam int unsigned       ADDR_W   = $clog2(DEPTH),
  parameter int unsigned        OUT_ADDR = DEPTH - 1,
  parameter logic [WIDTH-1:0]   HALT_OP  = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic        [WIDTH-1:0]  rom_addr,
  input  logic signed [WIDTH-1:0]  rom_data,
  output logic        [ADDR_W-1:0] pc,
  output logic signed [WIDTH-1:0]  acc,
  output logic                     loading,
  output logic                     halted,
  output logic                     out_valid,
  output logic signed [WIDTH-1:0]  out_data
);

  typedef enum logic [1:0] {StLoad, StFetch, StExec, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  opr_q, opr_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [WIDTH-1:0]  ram [DEPTH];
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [WIDTH-1:0]  ram_wdata;

  logic [ADDR_W-1:0] op_addr;
  logic [WIDTH-1:0]  diff;

  // Upper operand bits are ignored, so every instruction word addresses some RAM cell.
  assign op_addr = opr_q[ADDR_W-1:0];
  assign diff    = ram[op_addr] - acc_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    opr_d       = opr_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = cnt_q;
    ram_wdata   = rom_data;
    if (en) begin
      unique case (state_q)
        StLoad: begin
          ram_we = 1'b1;
          // Counter parks on the last address so rom_addr keeps its final LOAD value.
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = StFetch;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        StFetch: begin
          opr_d   = ram[pc_q];
          state_d = StExec;
        end
        StExec: begin
          if (opr_q == HALT_OP) begin
            state_d = StHalt;
          end else begin
            ram_we    = 1'b1;
            ram_waddr = op_addr;
            ram_wdata = diff;
            acc_d     = diff;
            pc_d      = pc_q + (diff[WIDTH-1] ? ADDR_W'(2) : ADDR_W'(1));
            state_d   = StFetch;
            if (op_addr == ADDR_W'(OUT_ADDR)) begin
              out_valid_d = 1'b1;
              out_data_d  = diff;
            end
          end
        end
        StHalt: begin
          state_d = StHalt;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      cnt_q       <= '0;
      pc_q        <= '0;
      acc_q       <= '0;
      opr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      opr_q       <= opr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // RAM is not reset; LOAD overwrites it after every reset.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  assign rom_addr  = WIDTH'(cnt_q);
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign loading   = (state_q == StLoad);
  assign halted    = (state_q == StHalt);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_rssb_core.sv
// Bench for rssb_core: directed program table, enable gaps, mid-run reset and random programs
// checked against an instruction-level reference model.
module tb_rssb_core;

  localparam int LIMIT = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] pc;
  logic [7:0] acc;
  logic       loading;
  logic       halted;
  logic       out_valid;
  logic [7:0] out_data;

  logic [7:0] rom [256];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  rssb_core dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pc        (pc),
    .acc       (acc),
    .loading   (loading),
    .halted    (halted),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: executes the program image instruction by instruction.
  logic [7:0] m_ram [16];
  logic [7:0] m_acc;
  int         m_pc;
  bit         m_halted;
  int         m_steps;
  int         m_nout;
  logic [7:0] m_last;

  function automatic void model_run(input int limit);
    logic [7:0] op;
    int a, r;
    m_acc = 0; m_pc = 0; m_halted = 0; m_steps = 0; m_nout = 0; m_last = 0;
    while (!m_halted && m_steps < limit) begin
      op = m_ram[m_pc];
      m_steps++;
      if (op == 8'hFF) begin
        m_halted = 1;
      end else begin
        a = int'(op) % 16;
        r = (int'(m_ram[a]) - int'(m_acc)) & 255;
        m_ram[a] = 8'(r);
        m_acc    = 8'(r);
        m_pc     = (m_pc + ((r >= 128) ? 2 : 1)) % 16;
        if (a == 15) begin
          m_nout++;
          m_last = 8'(r);
        end
      end
    end
  endfunction

  int         d_enabled;
  int         d_nout;
  logic [7:0] d_last;

  task automatic run_prog(input logic [15:0][7:0] im, input int gap_load, input int gap_exec);
    int cyc, gap, total, bad;
    bit used_l, used_e;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      rom[i]   = im[i];
      m_ram[i] = im[i];
    end
    model_run(LIMIT);
    total = 16 + 2 * m_steps;

    rst = 1'b1; en = 1'b1;
    tick();
    check("reset loading", loading, 1);
    check("reset halted", halted, 0);
    check("reset pc", pc, 0);
    check("reset acc", acc, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset rom_addr", rom_addr, 0);
    rst = 1'b0;

    d_enabled = 0; cyc = 0; gap = 0; used_l = 0; used_e = 0; d_nout = 0; d_last = 0;
    while (!(m_halted ? (halted === 1'b1) : (d_enabled == total)) && cyc < total + 20) begin
      if (gap == 0 && !used_l && d_enabled == gap_load) begin used_l = 1; gap = 5; end
      if (gap == 0 && !used_e && d_enabled == gap_exec) begin used_e = 1; gap = 5; end
      if (gap > 0) begin en = 1'b0; gap--; end
      else en = 1'b1;
      if (d_enabled < 16) begin
        check("load rom_addr", rom_addr, d_enabled);
        check("load loading", loading, 1);
      end
      tick();
      cyc++;
      if (en) d_enabled++;
      if (!en) check("out_valid with en low", out_valid, 0);
      if (out_valid === 1'b1) begin
        d_nout++;
        d_last = out_data;
      end
      if (en && d_enabled == 16) begin
        check("loading after copy", loading, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (dut.ram[i] !== im[i]) bad++;
        check("ram after load", bad, 0);
      end
    end
    check("run bound", (cyc < total + 20), 1);
    check("enabled cycles", d_enabled, total);
    check("halted vs model", halted, m_halted);
    check("pc vs model", pc, m_pc);
    check("acc vs model", acc, m_acc);
    bad = 0;
    for (int i = 0; i < 16; i++) if (dut.ram[i] !== m_ram[i]) bad++;
    check("ram vs model", bad, 0);
    check("out pulses vs model", d_nout, m_nout);
    if (m_nout > 0) check("out_data vs model", d_last, m_last);
  endtask

  typedef struct {
    string            name;
    logic [15:0][7:0] img;
    bit               has_exp;
    logic [7:0]       acc;
    logic [3:0]       pc;
    int               cycles;
    int               nout;
    logic [7:0]       last;
    int               gap_load;
    int               gap_exec;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [15:0][7:0] im;
    rst = 1'b1;
    en  = 1'b0;

    for (int i = 0; i < 16; i++) im[i] = 8'(i + 1);
    vecs[0] = '{"load", im, 1'b0, 8'h00, 4'd0, 0, 0, 8'h00, -1, -1};

    im = '0; im[0] = 8'h05; im[1] = 8'h05; im[2] = 8'hFF; im[5] = 8'h03;
    vecs[1] = '{"basic", im, 1'b1, 8'h00, 4'd2, 22, 0, 8'h00, -1, -1};
    vecs[2] = '{"basic gaps", im, 1'b1, 8'h00, 4'd2, 22, 0, 8'h00, 7, 17};

    im = '0; im[0] = 8'h06; im[1] = 8'h07; im[2] = 8'hFF; im[3] = 8'h08; im[4] = 8'hFF;
    im[6] = 8'h03; im[7] = 8'h01;
    vecs[3] = '{"skip", im, 1'b1, 8'h02, 4'd4, 24, 0, 8'h00, 3, 19};

    im = '0; im[0] = 8'h0F; im[1] = 8'hFF; im[15] = 8'h09;
    vecs[4] = '{"outport", im, 1'b1, 8'h09, 4'd1, 20, 1, 8'h09, -1, -1};

    for (int i = 2; i < 14; i++) im[i] = 8'h02;
    im[0] = 8'h01; im[1] = 8'hFF; im[14] = 8'h00; im[15] = 8'h0E;
    vecs[5] = '{"wrap", im, 1'b1, 8'hFF, 4'd1, 48, 0, 8'h00, -1, -1};

    for (int v = 0; v < 6; v++) begin
      run_prog(vecs[v].img, vecs[v].gap_load, vecs[v].gap_exec);
      if (vecs[v].has_exp) begin
        check({vecs[v].name, " halted"}, halted, 1);
        check({vecs[v].name, " acc"}, acc, vecs[v].acc);
        check({vecs[v].name, " pc"}, pc, vecs[v].pc);
        check({vecs[v].name, " cycles"}, d_enabled, vecs[v].cycles);
        check({vecs[v].name, " out pulses"}, d_nout, vecs[v].nout);
        if (vecs[v].nout > 0) check({vecs[v].name, " out_data"}, d_last, vecs[v].last);
      end
    end

    // Reset in the middle of execution restarts the copy and restores the image.
    im = vecs[3].img;
    for (int i = 0; i < 16; i++) rom[i] = im[i];
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("mid-run self write", dut.ram[7], 8'hFE);
    rst = 1'b1;
    tick();
    check("mid reset loading", loading, 1);
    check("mid reset pc", pc, 0);
    check("mid reset acc", acc, 0);
    check("mid reset rom_addr", rom_addr, 0);
    check("mid reset halted", halted, 0);
    rst = 1'b0;
    tick();
    check("restart rom_addr", rom_addr, 1);
    repeat (15) tick();
    check("restart loading", loading, 0);
    check("restart ram[7]", dut.ram[7], 8'h01);
    check("restart ram[6]", dut.ram[6], 8'h03);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 16; i++)
        im[i] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
      if (n % 3 == 0) run_prog(im, int'($urandom_range(0, 15)), 17 + 2 * int'($urandom_range(0, 3)));
      else run_prog(im, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
